// File: rtl/gen3_scr_pkg.sv
// ============================================================================
// Module : gen3_scr_pkg
// Brief  : Shared constants, FSM state and action encodings for the Gen3
//          per-lane scrambler sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gen3_scr_pkg;

  localparam logic [1:0]  SH_DATA      = 2'b10;
  localparam logic [1:0]  SH_OS        = 2'b01;
  localparam logic [7:0]  EIEOS        = 8'h00;
  localparam logic [7:0]  SKP          = 8'hAA;
  localparam logic [22:0] DEFAULT_SEED = 23'h1DBFBC;

  // Galois feedback taps for x^23+x^21+x^16+x^8+x^5+x^2+1 (bit 22 shifts out)
  localparam logic [22:0] LFSR_TAPS    = 23'h210125;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    DATA    = 3'd1,
    OS_SCR  = 3'd2,
    OS_HOLD = 3'd3,
    BAD     = 3'd4
  } scr_state_e;

  typedef enum logic [1:0] {
    ACT_HOLD     = 2'd0,
    ACT_BYPASS   = 2'd1,
    ACT_SCRAMBLE = 2'd2
  } scr_act_e;

endpackage

`default_nettype wire

// File: rtl/gen3_scramble_ctrl_if.sv
// ============================================================================
// Module : gen3_scramble_ctrl_if
// Brief  : Symbol bus between block framer, scrambler and lane serializer.
//          Counter outputs exist only when GEN3_SCR_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gen3_scramble_ctrl_if;

  logic       valid_i;
  logic [7:0] data_i;
  logic       blk_start_i;
  logic [1:0] sync_hdr_i;
  logic       valid_o;
  logic [7:0] data_o;
  logic       blk_start_o;
  logic [1:0] sync_hdr_o;
  logic       frame_err_o;
`ifdef GEN3_SCR_CNT_EN
  logic [15:0] data_blk_cnt_o;
  logic [15:0] os_blk_cnt_o;
`endif

  modport master (
    output valid_i, data_i, blk_start_i, sync_hdr_i,
`ifdef GEN3_SCR_CNT_EN
    input  data_blk_cnt_o, os_blk_cnt_o,
`endif
    input  valid_o, data_o, blk_start_o, sync_hdr_o, frame_err_o
  );

  modport slave (
    input  valid_i, data_i, blk_start_i, sync_hdr_i,
`ifdef GEN3_SCR_CNT_EN
    output data_blk_cnt_o, os_blk_cnt_o,
`endif
    output valid_o, data_o, blk_start_o, sync_hdr_o, frame_err_o
  );

endinterface

`default_nettype wire

// File: rtl/gen3_lfsr8_step.sv
// ============================================================================
// Module : gen3_lfsr8_step
// Brief  : Combinational 8-shift LFSR advance; mask bit i is the bit shifted
//          out on shift i (LSB first).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gen3_lfsr8_step
  import gen3_scr_pkg::*;
(
  input  logic [22:0] lfsr_i,
  output logic [7:0]  mask_o,
  output logic [22:0] lfsr_o
);

  logic [22:0] w_s;

  always_comb begin
    w_s    = lfsr_i;
    mask_o = '0;
    for (int i = 0; i < 8; i++) begin
      mask_o[i] = w_s[22];
      w_s       = {w_s[21:0], 1'b0} ^ (w_s[22] ? LFSR_TAPS : 23'd0);
    end
    lfsr_o = w_s;
  end

endmodule

`default_nettype wire

// File: rtl/gen3_scramble_ctrl.sv
// ============================================================================
// Module : gen3_scramble_ctrl
// Brief  : Per-lane Gen3 128b/130b scrambler sequencer: block framing, LFSR
//          ownership and per-symbol scramble/bypass/hold/reseed decision.
//          Optional block counters enabled by GEN3_SCR_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gen3_scramble_ctrl
  import gen3_scr_pkg::*;
#(
  parameter logic [22:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          BLK_SYMS  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gen3_scramble_ctrl_if.slave  lane
);

  localparam int                  c_cnt_w    = $clog2(BLK_SYMS);
  localparam logic [c_cnt_w-1:0]  c_last_sym = c_cnt_w'(BLK_SYMS - 1);

  scr_state_e         r_state;
  scr_state_e         w_state_nxt;
  logic [22:0]        r_lfsr;
  logic [c_cnt_w-1:0] r_sym_cnt;
  logic               r_reseed;
  logic               r_valid;
  logic [7:0]         r_data;
  logic               r_blk_start;
  logic [1:0]         r_sync_hdr;
  logic               r_frame_err;

  scr_act_e           w_act;
  logic               w_frame_err;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_reseed_nxt;
  logic               w_seed_load;
  logic [7:0]         w_mask;
  logic [22:0]        w_lfsr_nxt;
  logic               w_hdr_ok;

  gen3_lfsr8_step u_step (
    .lfsr_i (r_lfsr),
    .mask_o (w_mask),
    .lfsr_o (w_lfsr_nxt)
  );

  assign w_hdr_ok = (lane.sync_hdr_i == SH_DATA) || (lane.sync_hdr_i == SH_OS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (lane.valid_i) begin
      if (lane.blk_start_i) begin
        if (lane.sync_hdr_i == SH_DATA)
          w_state_nxt = DATA;
        else if (lane.sync_hdr_i == SH_OS)
          w_state_nxt = (lane.data_i == EIEOS || lane.data_i == SKP) ? OS_HOLD : OS_SCR;
        else
          w_state_nxt = BAD;
      end else if (r_sym_cnt == '0) begin
        w_state_nxt = HUNT;
      end
    end
  end

  // Symbol 0 action follows the newly decoded block type; later symbols follow the held state.
  always_comb begin
    w_act        = ACT_HOLD;
    w_frame_err  = 1'b0;
    w_cnt_nxt    = r_sym_cnt;
    w_reseed_nxt = r_reseed;
    w_seed_load  = 1'b0;
    if (lane.valid_i) begin
      if (lane.blk_start_i) begin
        w_frame_err  = (r_sym_cnt != '0) || !w_hdr_ok;
        w_cnt_nxt    = c_cnt_w'(1);
        w_reseed_nxt = (lane.sync_hdr_i == SH_OS) && (lane.data_i == EIEOS);
        case (w_state_nxt)
          DATA:    w_act = ACT_SCRAMBLE;
          OS_SCR:  w_act = ACT_BYPASS;
          default: w_act = ACT_HOLD;
        endcase
      end else if (r_sym_cnt == '0) begin
        w_frame_err = 1'b1;
      end else begin
        case (r_state)
          DATA, OS_SCR: w_act = ACT_SCRAMBLE;
          default:      w_act = ACT_HOLD;
        endcase
        if (r_sym_cnt == c_last_sym) begin
          w_cnt_nxt    = '0;
          w_seed_load  = r_reseed;
          w_reseed_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_sym_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr      <= LFSR_SEED;
      r_sym_cnt   <= '0;
      r_reseed    <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_blk_start <= 1'b0;
      r_sync_hdr  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= lane.valid_i;
      r_frame_err <= w_frame_err;
      if (lane.valid_i) begin
        r_data      <= (w_act == ACT_SCRAMBLE) ? (lane.data_i ^ w_mask) : lane.data_i;
        r_blk_start <= lane.blk_start_i;
        r_sync_hdr  <= lane.sync_hdr_i;
        r_sym_cnt   <= w_cnt_nxt;
        r_reseed    <= w_reseed_nxt;
        if (w_seed_load)
          r_lfsr <= LFSR_SEED;
        else if (w_act != ACT_HOLD)
          r_lfsr <= w_lfsr_nxt;
      end
    end
  end

  assign lane.valid_o     = r_valid;
  assign lane.data_o      = r_data;
  assign lane.blk_start_o = r_blk_start;
  assign lane.sync_hdr_o  = r_sync_hdr;
  assign lane.frame_err_o = r_frame_err;

`ifdef GEN3_SCR_CNT_EN
  logic [15:0] r_data_blk_cnt;
  logic [15:0] r_os_blk_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data_blk_cnt <= '0;
      r_os_blk_cnt   <= '0;
    end else if (lane.valid_i && lane.blk_start_i) begin
      if (lane.sync_hdr_i == SH_DATA && r_data_blk_cnt != 16'hFFFF)
        r_data_blk_cnt <= r_data_blk_cnt + 16'd1;
      if (lane.sync_hdr_i == SH_OS && r_os_blk_cnt != 16'hFFFF)
        r_os_blk_cnt <= r_os_blk_cnt + 16'd1;
    end
  end

  assign lane.data_blk_cnt_o = r_data_blk_cnt;
  assign lane.os_blk_cnt_o   = r_os_blk_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gen3_scramble_ctrl.sv
// ============================================================================
// Module : tb_gen3_scramble_ctrl
// Brief  : Self-checking bench for gen3_scramble_ctrl with a serial-LFSR
//          reference model feeding an expected-output queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gen3_scramble_ctrl;

  localparam logic [22:0] c_seed = 23'h1DBFBC;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       bs;
    logic [1:0] h;
    logic       e;
  } obs_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  gen3_scramble_ctrl_if bus();

  gen3_scramble_ctrl #(.LFSR_SEED(c_seed), .BLK_SYMS(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .lane  (bus)
  );

  always #5 clk_i = ~clk_i;

  int   checks   = 0;
  int   failures = 0;
  obs_t sb[$];
  obs_t last_exp;

  // Reference model state; mode 0=hunt 1=scramble 2=bypass-advance sym0 3=hold
  logic [22:0] m_lfsr;
  int          m_cnt;
  int          m_mode;
  bit          m_reseed;
  int          m_dcnt;
  int          m_ocnt;

  function automatic logic [22:0] golden_step(input logic [22:0] s_in, output logic [7:0] m);
    logic [22:0] s;
    logic        o;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      o    = s[22];
      m[i] = o;
      s    = {s[21:0], 1'b0};
      if (o) begin
        s[21] = ~s[21]; s[16] = ~s[16]; s[8] = ~s[8];
        s[5]  = ~s[5];  s[2]  = ~s[2];  s[0] = ~s[0];
      end
    end
    return s;
  endfunction

  function automatic obs_t sample();
    return {bus.valid_o, bus.data_o, bus.blk_start_o, bus.sync_hdr_o, bus.frame_err_o};
  endfunction

  task automatic model_reset();
    m_lfsr = c_seed; m_cnt = 0; m_mode = 0; m_reseed = 0;
    m_dcnt = 0; m_ocnt = 0; last_exp = '0;
    sb.delete();
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit bs, input logic [1:0] h);
    obs_t        e;
    logic [7:0]  mk;
    logic [22:0] nx;
    bit          scr, adv;
    @(negedge clk_i);
    bus.valid_i = v; bus.data_i = d; bus.blk_start_i = bs; bus.sync_hdr_i = h;
    nx = golden_step(m_lfsr, mk);
    e = last_exp; e.v = v; e.e = 1'b0; scr = 0; adv = 0;
    if (v) begin
      if (bs) begin
        e.e = (m_cnt != 0); m_cnt = 1; m_reseed = 0;
        if (h == 2'b10) begin
          m_mode = 1; if (m_dcnt < 65535) m_dcnt++;
        end else if (h == 2'b01) begin
          if (m_ocnt < 65535) m_ocnt++;
          if (d == 8'h00) begin m_mode = 3; m_reseed = 1; end
          else if (d == 8'hAA) m_mode = 3;
          else m_mode = 2;
        end else begin
          m_mode = 3; e.e = 1'b1;
        end
        scr = (m_mode == 1); adv = (m_mode == 1 || m_mode == 2);
      end else if (m_cnt == 0) begin
        e.e = 1'b1; m_mode = 0;
      end else begin
        scr = (m_mode == 1 || m_mode == 2); adv = scr;
        m_cnt++;
      end
      e.d = scr ? (d ^ mk) : d; e.bs = bs; e.h = h;
      if (adv) m_lfsr = nx;
      if (m_cnt == 16) begin
        m_cnt = 0;
        if (m_reseed) begin m_lfsr = c_seed; m_reseed = 0; end
      end
    end
    last_exp = e;
    sb.push_back(e);
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    obs_t got;
    repeat (3) @(posedge clk_i);
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 13'h0); end
`ifdef GEN3_SCR_CNT_EN
    checks++;
    if (bus.data_blk_cnt_o !== 16'd0 || bus.os_blk_cnt_o !== 16'd0) begin
      failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", bus.data_blk_cnt_o, bus.os_blk_cnt_o);
    end
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_data_blocks();
    obs_t got, exp;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 16; s++) begin
        drive(1, (b == 0 && s == 0) ? 8'h00 : 8'($urandom), s == 0, 2'b10);
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL data_block b=%0d s=%0d got=%h exp=%h", b, s, got, exp); end
        if (b == 0 && s == 0) begin
          checks++;
          if (bus.data_o !== 8'h6C || bus.valid_o !== 1'b1) begin
            failures++; $display("FAIL data_sym0_mask got=%h exp=6c", bus.data_o);
          end
        end
      end
    end
  endtask

  task automatic test_eieos();
    obs_t       got, exp;
    logic [7:0] d;
    int         kind;
    // Block kinds: 0 data, 1 EIEOS
    for (int b = 0; b < 4; b++) begin
      kind = (b == 2) ? 1 : 0;
      for (int s = 0; s < 16; s++) begin
        if (kind == 1) d = (s == 0) ? 8'h00 : 8'hFF;
        else           d = (b == 3 && s == 0) ? 8'h00 : 8'($urandom);
        drive(1, d, s == 0, kind == 1 ? 2'b01 : 2'b10);
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL eieos_seq b=%0d s=%0d got=%h exp=%h", b, s, got, exp); end
        if (kind == 1) begin
          checks++;
          if (bus.data_o !== d) begin failures++; $display("FAIL eieos_bypass s=%0d got=%h exp=%h", s, bus.data_o, d); end
        end
        if (b == 3 && s == 0) begin
          checks++;
          if (bus.data_o !== 8'h6C) begin failures++; $display("FAIL eieos_reseed got=%h exp=6c", bus.data_o); end
        end
      end
    end
  endtask

  task automatic test_skp();
    obs_t       got, exp;
    logic [7:0] d;
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 16; s++) begin
        d = (b == 1 && s == 0) ? 8'hAA : 8'($urandom);
        drive(1, d, s == 0, b == 1 ? 2'b01 : 2'b10);
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL skp_seq b=%0d s=%0d got=%h exp=%h", b, s, got, exp); end
        if (b == 1) begin
          checks++;
          if (bus.data_o !== d) begin failures++; $display("FAIL skp_bypass s=%0d got=%h exp=%h", s, bus.data_o, d); end
        end
      end
    end
  endtask

  task automatic test_ts1();
    obs_t got, exp;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 16; s++) begin
        drive(1, (b == 0 && s == 0) ? 8'h1E : 8'($urandom), s == 0, b == 0 ? 2'b01 : 2'b10);
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL ts1_seq b=%0d s=%0d got=%h exp=%h", b, s, got, exp); end
        if (b == 0 && s == 0) begin
          checks++;
          if (bus.data_o !== 8'h1E) begin failures++; $display("FAIL ts1_sym0 got=%h exp=1e", bus.data_o); end
        end
      end
    end
  endtask

  task automatic test_framing();
    obs_t got, exp;
    // Early block start at sym_cnt 7, then the realigned block runs to completion
    for (int s = 0; s < 23; s++) begin
      drive(1, 8'($urandom), (s == 0 || s == 7), 2'b10);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL realign s=%0d got=%h exp=%h", s, got, exp); end
      if (s == 7) begin
        checks++;
        if (bus.frame_err_o !== 1'b1) begin failures++; $display("FAIL realign_err got=%b exp=1", bus.frame_err_o); end
      end
    end
    // Illegal header 2'b11: error pulse, whole block passes through
    for (int s = 0; s < 16; s++) begin
      drive(1, 8'($urandom), s == 0, 2'b11);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL bad_hdr s=%0d got=%h exp=%h", s, got, exp); end
      if (s == 0) begin
        checks++;
        if (bus.frame_err_o !== 1'b1) begin failures++; $display("FAIL bad_hdr_err got=%b exp=1", bus.frame_err_o); end
      end
    end
    // Missing block start at the boundary drops to HUNT, then a data block with idle gaps
    for (int s = 0; s < 3; s++) begin
      drive(1, 8'($urandom), 0, 2'b10);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL hunt s=%0d got=%h exp=%h", s, got, exp); end
      if (s == 0) begin
        checks++;
        if (bus.frame_err_o !== 1'b1) begin failures++; $display("FAIL hunt_err got=%b exp=1", bus.frame_err_o); end
      end
    end
    for (int s = 0; s < 20; s++) begin
      if (s % 5 == 4) drive(0, 8'($urandom), 0, 2'b00);
      else            drive(1, 8'($urandom), s == 0, 2'b10);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL gap_block s=%0d got=%h exp=%h", s, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    for (int s = 0; s < 10; s++) begin
      drive(1, 8'($urandom), s == 0, 2'b10);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL pre_reset s=%0d got=%h exp=%h", s, got, exp); end
    end
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== '0) begin failures++; $display("FAIL mid_reset got=%h exp=%h", got, 13'h0); end
`ifdef GEN3_SCR_CNT_EN
    checks++;
    if (bus.data_blk_cnt_o !== 16'd0 || bus.os_blk_cnt_o !== 16'd0) begin
      failures++; $display("FAIL mid_reset_counters got=%h/%h exp=0/0", bus.data_blk_cnt_o, bus.os_blk_cnt_o);
    end
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int s = 0; s < 16; s++) begin
      drive(1, s == 0 ? 8'h00 : 8'($urandom), s == 0, 2'b10);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL post_reset s=%0d got=%h exp=%h", s, got, exp); end
      if (s == 0) begin
        checks++;
        if (bus.data_o !== 8'h6C) begin failures++; $display("FAIL post_reset_mask got=%h exp=6c", bus.data_o); end
      end
    end
  endtask

  task automatic test_counters();
`ifdef GEN3_SCR_CNT_EN
    checks++;
    if (bus.data_blk_cnt_o !== 16'(m_dcnt) || bus.os_blk_cnt_o !== 16'(m_ocnt)) begin
      failures++; $display("FAIL blk_counters got=%h/%h exp=%h/%h", bus.data_blk_cnt_o, bus.os_blk_cnt_o, 16'(m_dcnt), 16'(m_ocnt));
    end
`endif
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.data_i = '0; bus.blk_start_i = 1'b0; bus.sync_hdr_i = '0;
    model_reset();
    test_reset();
    test_data_blocks();
    test_eieos();
    test_skp();
    test_ts1();
    test_framing();
    test_counters();
    test_reset_mid();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
